// File: rtl/tank_keys_decoder.sv
// tank_keys_decoder
//
// Purpose:
//   Turns the PS/2 scan-code byte stream into the held-key vector used by the
//   tank movement logic, plus fire signals for the missile logic. Understands
//   make codes, break codes (F0 prefix) and extended codes (E0 prefix). Key
//   codes and their extended-ness are parameters, so one instance serves each
//   player.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   din[7:0]    received PS/2 byte, valid only while dinNew=1
//   dinNew      one-cycle strobe marking a new byte on din
//   keyPressed  held keys: [0]=down, [1]=up, [2]=left, [3]=right
//   fireHeld    fire key currently held
//   firePulse   one-cycle pulse on the first make of fire
module tank_keys_decoder #(
  parameter logic [7:0]  UP_CODE        = 8'h75,
  parameter logic [7:0]  DOWN_CODE      = 8'h72,
  parameter logic [7:0]  LEFT_CODE      = 8'h6B,
  parameter logic [7:0]  RIGHT_CODE     = 8'h74,
  parameter logic [7:0]  FIRE_CODE      = 8'h29,
  parameter bit          DIR_EXTENDED   = 1'b1,
  parameter bit          FIRE_EXTENDED  = 1'b0,
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dinNew,
  output logic [3:0] keyPressed,
  output logic       fireHeld,
  output logic       firePulse
);

  localparam logic [7:0]  EXT_PREFIX  = 8'hE0;
  localparam logic [7:0]  BRK_PREFIX  = 8'hF0;
  localparam logic [15:0] TIMEOUT_LAST = 16'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  keys_q, keys_d;
  logic        fireHeld_q, fireHeld_d;
  logic        firePulse_q, firePulse_d;

  // Classification of the current byte: a code byte (neither prefix) takes
  // its extended/break flags from the prefix state it arrives in.
  logic       codeValid;
  logic       codeExt;
  logic       codeBreak;
  logic       dirOk;
  logic [3:0] dirHit;
  logic       fireHit;

  always_comb begin
    codeValid = 1'b0;
    codeExt   = 1'b0;
    codeBreak = 1'b0;
    if (dinNew && (din != EXT_PREFIX) && (din != BRK_PREFIX)) begin
      codeValid = 1'b1;
      codeExt   = (state_q == EXT) || (state_q == EXT_BRK);
      codeBreak = (state_q == BRK) || (state_q == EXT_BRK);
    end
  end

  // A key matches only when both the code and its E0-prefix status agree,
  // which is how e.g. keypad 8 (75) is told apart from arrow-up (E0 75).
  always_comb begin
    dirOk     = codeValid && (codeExt == DIR_EXTENDED);
    dirHit[0] = dirOk && (din == DOWN_CODE);
    dirHit[1] = dirOk && (din == UP_CODE);
    dirHit[2] = dirOk && (din == LEFT_CODE);
    dirHit[3] = dirOk && (din == RIGHT_CODE);
    fireHit   = codeValid && (codeExt == FIRE_EXTENDED) && (din == FIRE_CODE);
  end

  // Prefix tracking. Repeated prefixes are absorbed; a stalled prefix state
  // falls back to IDLE after the timeout, but a byte arriving on the very
  // cycle the timeout expires is still decoded with the prefix.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (dinNew) begin
      timer_d = 16'd0;
      unique case (state_q)
        IDLE: begin
          if (din == EXT_PREFIX)      state_d = EXT;
          else if (din == BRK_PREFIX) state_d = BRK;
          else                        state_d = IDLE;
        end
        EXT: begin
          if (din == BRK_PREFIX)      state_d = EXT_BRK;
          else if (din == EXT_PREFIX) state_d = EXT;
          else                        state_d = IDLE;
        end
        BRK: begin
          if (din == BRK_PREFIX)      state_d = BRK;
          else if (din == EXT_PREFIX) state_d = EXT_BRK;
          else                        state_d = IDLE;
        end
        EXT_BRK: begin
          if ((din == BRK_PREFIX) || (din == EXT_PREFIX)) state_d = EXT_BRK;
          else                                            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      timer_d = 16'd0;
    end else if (timer_q == TIMEOUT_LAST) begin
      state_d = IDLE;
      timer_d = 16'd0;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Held-key and fire bookkeeping. dirHit/fireHit are zero for anything that
  // is not a matching code, so non-matching bytes leave everything alone.
  always_comb begin
    keys_d      = codeBreak ? (keys_q & ~dirHit) : (keys_q | dirHit);
    fireHeld_d  = fireHeld_q;
    firePulse_d = 1'b0;
    if (fireHit) begin
      fireHeld_d  = !codeBreak;
      firePulse_d = !codeBreak && !fireHeld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      keys_q      <= 4'b0000;
      fireHeld_q  <= 1'b0;
      firePulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      keys_q      <= keys_d;
      fireHeld_q  <= fireHeld_d;
      firePulse_q <= firePulse_d;
    end
  end

  assign keyPressed = keys_q;
  assign fireHeld   = fireHeld_q;
  assign firePulse  = firePulse_q;

endmodule

// File: tb/tb_tank_keys_decoder.sv
// Testbench for tank_keys_decoder. Three instances share one stimulus stream:
// the default configuration, one with unprefixed directions and UP=1D, and
// one with a short prefix timeout of 8 cycles.
module tb_tank_keys_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       dinNew;

  logic [3:0] keys;
  logic       fireHeld;
  logic       firePulse;
  logic [3:0] keysAlt;
  logic       fireHeldAlt;
  logic       firePulseAlt;
  logic [3:0] keysTo;
  logic       fireHeldTo;
  logic       firePulseTo;

  int checks = 0;
  int passed = 0;

  tank_keys_decoder dut (
    .clk(clk), .reset(reset), .din(din), .dinNew(dinNew),
    .keyPressed(keys), .fireHeld(fireHeld), .firePulse(firePulse)
  );

  tank_keys_decoder #(.DIR_EXTENDED(1'b0), .UP_CODE(8'h1D)) dutAlt (
    .clk(clk), .reset(reset), .din(din), .dinNew(dinNew),
    .keyPressed(keysAlt), .fireHeld(fireHeldAlt), .firePulse(firePulseAlt)
  );

  tank_keys_decoder #(.PREFIX_TIMEOUT(8)) dutTo (
    .clk(clk), .reset(reset), .din(din), .dinNew(dinNew),
    .keyPressed(keysTo), .fireHeld(fireHeldTo), .firePulse(firePulseTo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the falling edge
  // after the rising edge that sampled the byte.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    din    = b;
    dinNew = 1'b1;
    @(negedge clk);
    dinNew = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Set up-key first, then reset while an E0 is strobed: reset must win.
    doReset();
    sendByte(8'hE0);
    sendByte(8'h75);
    @(negedge clk);
    reset  = 1'b1;
    din    = 8'hE0;
    dinNew = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    dinNew = 1'b0;
    checks++;
    if ({keys, fireHeld, firePulse} !== 6'b0) $display("[TB] FAIL reset_outputs got=%b want=000000", {keys, fireHeld, firePulse});
    else passed++;
    // E0 was overridden, so 75 is unprefixed and must not match.
    sendByte(8'h75);
    checks++;
    if (keys !== 4'b0000) $display("[TB] FAIL reset_overrides_din got=%b want=0000", keys);
    else passed++;
  endtask

  task automatic test_up_make_break();
    doReset();
    sendByte(8'hE0);
    checks++;
    if (keys !== 4'b0000) $display("[TB] FAIL prefix_only got=%b want=0000", keys);
    else passed++;
    sendByte(8'h75);
    checks++;
    if (keys !== 4'b0010) $display("[TB] FAIL up_make got=%b want=0010", keys);
    else passed++;
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    checks++;
    if (keys !== 4'b0000) $display("[TB] FAIL up_break got=%b want=0000", keys);
    else passed++;
  endtask

  task automatic test_left_right();
    doReset();
    sendByte(8'hE0);
    sendByte(8'h6B);
    sendByte(8'hE0);
    sendByte(8'h74);
    checks++;
    if (keys !== 4'b1100) $display("[TB] FAIL left_right got=%b want=1100", keys);
    else passed++;
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h6B);
    checks++;
    if (keys !== 4'b1000) $display("[TB] FAIL left_release got=%b want=1000", keys);
    else passed++;
    // Break for a key that is not held leaves it clear.
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h72);
    checks++;
    if (keys !== 4'b1000) $display("[TB] FAIL break_not_held got=%b want=1000", keys);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // E0 and 72 on consecutive cycles, then junk bytes that must not matter.
    doReset();
    @(negedge clk);
    din = 8'hE0; dinNew = 1'b1;
    @(negedge clk);
    din = 8'h72;
    @(negedge clk);
    dinNew = 1'b0;
    checks++;
    if (keys !== 4'b0001) $display("[TB] FAIL back_to_back got=%b want=0001", keys);
    else passed++;
    sendByte(8'hAA);
    sendByte(8'hFA);
    sendByte(8'h00);
    checks++;
    if ({keys, fireHeld} !== 5'b00010) $display("[TB] FAIL junk_bytes got=%b want=00010", {keys, fireHeld});
    else passed++;
  endtask

  task automatic test_fire();
    doReset();
    sendByte(8'h29);
    checks++;
    if ({fireHeld, firePulse} !== 2'b11) $display("[TB] FAIL fire_first got=%b want=11", {fireHeld, firePulse});
    else passed++;
    @(negedge clk);
    checks++;
    if ({fireHeld, firePulse} !== 2'b10) $display("[TB] FAIL fire_pulse_width got=%b want=10", {fireHeld, firePulse});
    else passed++;
    sendByte(8'h29);
    checks++;
    if ({fireHeld, firePulse} !== 2'b10) $display("[TB] FAIL fire_repeat1 got=%b want=10", {fireHeld, firePulse});
    else passed++;
    sendByte(8'h29);
    checks++;
    if ({fireHeld, firePulse} !== 2'b10) $display("[TB] FAIL fire_repeat2 got=%b want=10", {fireHeld, firePulse});
    else passed++;
    sendByte(8'hF0);
    sendByte(8'h29);
    checks++;
    if ({fireHeld, firePulse} !== 2'b00) $display("[TB] FAIL fire_release got=%b want=00", {fireHeld, firePulse});
    else passed++;
    // Extended fire code does not match when FIRE_EXTENDED=0.
    sendByte(8'hE0);
    sendByte(8'h29);
    checks++;
    if ({fireHeld, firePulse} !== 2'b00) $display("[TB] FAIL fire_ext_ignored got=%b want=00", {fireHeld, firePulse});
    else passed++;
  endtask

  task automatic test_extended_rule();
    doReset();
    sendByte(8'h75);
    checks++;
    if (keys !== 4'b0000) $display("[TB] FAIL unprefixed_up got=%b want=0000", keys);
    else passed++;
    sendByte(8'h1D);
    checks++;
    if (keysAlt !== 4'b0010) $display("[TB] FAIL alt_up_make got=%b want=0010", keysAlt);
    else passed++;
    sendByte(8'hE0);
    sendByte(8'h72);
    checks++;
    if (keysAlt !== 4'b0010) $display("[TB] FAIL alt_ext_down_ignored got=%b want=0010", keysAlt);
    else passed++;
  endtask

  task automatic test_timeout();
    // Idle edges between E0 and the 72 strobe are waitCycles+1.
    doReset();
    sendByte(8'hE0);
    repeat (7) @(negedge clk);
    sendByte(8'h72);
    checks++;
    if (keysTo !== 4'b0000) $display("[TB] FAIL timeout_expired got=%b want=0000", keysTo);
    else passed++;
    doReset();
    sendByte(8'hE0);
    repeat (6) @(negedge clk);
    sendByte(8'h72);
    checks++;
    if (keysTo !== 4'b0001) $display("[TB] FAIL timeout_boundary got=%b want=0001", keysTo);
    else passed++;
    doReset();
    sendByte(8'hE0);
    repeat (2) @(negedge clk);
    sendByte(8'h72);
    checks++;
    if (keysTo !== 4'b0001) $display("[TB] FAIL timeout_early got=%b want=0001", keysTo);
    else passed++;
  endtask

  task automatic test_mid_reset();
    doReset();
    sendByte(8'hE0);
    sendByte(8'h72);
    sendByte(8'hE0);
    sendByte(8'h75);
    checks++;
    if (keys !== 4'b0011) $display("[TB] FAIL mid_setup got=%b want=0011", keys);
    else passed++;
    sendByte(8'hE0);
    doReset();
    checks++;
    if ({keys, fireHeld, firePulse} !== 6'b0) $display("[TB] FAIL mid_reset got=%b want=000000", {keys, fireHeld, firePulse});
    else passed++;
    sendByte(8'h72);
    checks++;
    if (keys !== 4'b0000) $display("[TB] FAIL mid_reset_next got=%b want=0000", keys);
    else passed++;
  endtask

  initial begin
    reset  = 1'b1;
    din    = 8'h00;
    dinNew = 1'b0;
    test_reset();
    test_up_make_break();
    test_left_right();
    test_back_to_back();
    test_fire();
    test_extended_rule();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
